// File: rtl/pic_bus_if.sv
`default_nettype none
// ============================================================================
// Module      : pic_bus_if
// Description : CPU command/register interface for the programmable interrupt
//               controller. Detects write/read strobes, sequences the
//               ICW1..ICW4 initialisation, decodes OCW1..OCW3, holds IMR and
//               the ICW fields, and returns IRR/ISR/IMR on a registered read
//               path.
// Ports       : CLK, RST_N          clock, async active-low reset
//               CS_N, WR_N, RD_N   bus strobes (active low)
//               A0, DIN            register address bit and write data
//               IRR, ISR           request / in-service registers from core
//               DOUT, DOUT_EN      registered read data and drive enable
//               IMR                interrupt mask register
//               ICW_PULSE          one-cycle strobe per accepted ICW1..ICW4
//               OCW_PULSE          one-cycle strobe per accepted OCW1..OCW3
//               LTIM, SNGL         ICW1 fields
//               VEC_BASE           ICW2 vector base
//               CASC_CFG           ICW3 contents
//               ICW4_REG, OCW2_REG ICW4 low bits, last OCW2 byte
//               INIT_DONE          initialisation complete
// Revision    : 1.0 - initial release
// ============================================================================
module pic_bus_if #(
    parameter int DATA_W     = 8,
    parameter bit CASCADE_EN = 1'b1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CS_N,
    input  logic              WR_N,
    input  logic              RD_N,
    input  logic              A0,
    input  logic [DATA_W-1:0] DIN,
    input  logic [DATA_W-1:0] IRR,
    input  logic [DATA_W-1:0] ISR,
    output logic [DATA_W-1:0] DOUT,
    output logic              DOUT_EN,
    output logic [DATA_W-1:0] IMR,
    output logic [3:0]        ICW_PULSE,
    output logic [2:0]        OCW_PULSE,
    output logic              LTIM,
    output logic              SNGL,
    output logic [DATA_W-4:0] VEC_BASE,
    output logic [DATA_W-1:0] CASC_CFG,
    output logic [4:0]        ICW4_REG,
    output logic [7:0]        OCW2_REG,
    output logic              INIT_DONE
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_ICW2 = 3'd1,
        ST_WAIT_ICW3 = 3'd2,
        ST_WAIT_ICW4 = 3'd3,
        ST_READY     = 3'd4
    } state_t;

    state_t              state_q,     state_d;
    logic                wr_n_q,      rd_n_q;
    logic [DATA_W-1:0]   imr_q,       imr_d;
    logic                init_done_q, init_done_d;
    logic                ltim_q,      ltim_d;
    logic                sngl_q,      sngl_d;
    logic                ic4_q,       ic4_d;
    logic [DATA_W-4:0]   vec_base_q,  vec_base_d;
    logic [DATA_W-1:0]   casc_cfg_q,  casc_cfg_d;
    logic [4:0]          icw4_reg_q,  icw4_reg_d;
    logic [7:0]          ocw2_reg_q,  ocw2_reg_d;
    logic                rd_sel_q,    rd_sel_d;    // 0 = IRR, 1 = ISR
    logic [3:0]          icw_pulse_q, icw_pulse_d;
    logic [2:0]          ocw_pulse_q, ocw_pulse_d;
    logic [DATA_W-1:0]   dout_q,      dout_d;
    logic                dout_en_q,   dout_en_d;

    logic wr_accept;
    logic rd_accept;
    logic is_icw1;

    // Falling edge of a strobe while selected. The read is suppressed when a
    // write edge lands on the same cycle. Because the edge is taken against
    // the registered strobe, deselecting mid-strobe cannot re-trigger.
    assign wr_accept = ~CS_N & ~WR_N & wr_n_q;
    assign rd_accept = ~CS_N & ~RD_N & rd_n_q & ~wr_accept;
    assign is_icw1   = ~A0 & DIN[4];

    always_comb begin
        state_d     = state_q;
        imr_d       = imr_q;
        init_done_d = init_done_q;
        ltim_d      = ltim_q;
        sngl_d      = sngl_q;
        ic4_d       = ic4_q;
        vec_base_d  = vec_base_q;
        casc_cfg_d  = casc_cfg_q;
        icw4_reg_d  = icw4_reg_q;
        ocw2_reg_d  = ocw2_reg_q;
        rd_sel_d    = rd_sel_q;
        icw_pulse_d = 4'b0000;
        ocw_pulse_d = 3'b000;

        if (wr_accept) begin
            if (is_icw1) begin
                // ICW1 restarts initialisation from any state.
                ltim_d      = DIN[3];
                sngl_d      = CASCADE_EN ? DIN[1] : 1'b1;
                ic4_d       = DIN[0];
                imr_d       = '0;
                init_done_d = 1'b0;
                rd_sel_d    = 1'b0;
                icw_pulse_d = 4'b0001;
                state_d     = ST_WAIT_ICW2;
            end else begin
                case (state_q)
                    ST_WAIT_ICW2: if (A0) begin
                        vec_base_d  = DIN[DATA_W-1:3];
                        icw_pulse_d = 4'b0010;
                        if (!sngl_q) begin
                            state_d = ST_WAIT_ICW3;
                        end else if (ic4_q) begin
                            state_d = ST_WAIT_ICW4;
                        end else begin
                            icw4_reg_d  = 5'd0;
                            init_done_d = 1'b1;
                            state_d     = ST_READY;
                        end
                    end
                    ST_WAIT_ICW3: if (A0) begin
                        casc_cfg_d  = DIN;
                        icw_pulse_d = 4'b0100;
                        if (ic4_q) begin
                            state_d = ST_WAIT_ICW4;
                        end else begin
                            icw4_reg_d  = 5'd0;
                            init_done_d = 1'b1;
                            state_d     = ST_READY;
                        end
                    end
                    ST_WAIT_ICW4: if (A0) begin
                        icw4_reg_d  = DIN[4:0];
                        icw_pulse_d = 4'b1000;
                        init_done_d = 1'b1;
                        state_d     = ST_READY;
                    end
                    ST_READY: begin
                        if (A0) begin
                            imr_d       = DIN;
                            ocw_pulse_d = 3'b001;
                        end else if (DIN[4:3] == 2'b00) begin
                            ocw2_reg_d  = DIN[7:0];
                            ocw_pulse_d = 3'b010;
                        end else begin
                            // DIN[4]=1 was taken as ICW1, so this is OCW3.
                            ocw_pulse_d = 3'b100;
                            if (DIN[1]) begin
                                rd_sel_d = DIN[0];
                            end
                        end
                    end
                    default: ; // IDLE: only ICW1 is meaningful
                endcase
            end
        end
    end

    always_comb begin
        dout_d = dout_q;
        if (rd_accept) begin
            dout_d = A0 ? imr_q : (rd_sel_q ? ISR : IRR);
        end
        // Enable rises with the data load and holds while the read strobe
        // and chip select stay asserted.
        dout_en_d = rd_accept | (dout_en_q & ~CS_N & ~RD_N);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            wr_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            imr_q       <= '0;
            init_done_q <= 1'b0;
            ltim_q      <= 1'b0;
            sngl_q      <= 1'b1;
            ic4_q       <= 1'b0;
            vec_base_q  <= '0;
            casc_cfg_q  <= '0;
            icw4_reg_q  <= 5'd0;
            ocw2_reg_q  <= 8'd0;
            rd_sel_q    <= 1'b0;
            icw_pulse_q <= 4'b0000;
            ocw_pulse_q <= 3'b000;
            dout_q      <= '0;
            dout_en_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_n_q      <= WR_N;
            rd_n_q      <= RD_N;
            imr_q       <= imr_d;
            init_done_q <= init_done_d;
            ltim_q      <= ltim_d;
            sngl_q      <= sngl_d;
            ic4_q       <= ic4_d;
            vec_base_q  <= vec_base_d;
            casc_cfg_q  <= casc_cfg_d;
            icw4_reg_q  <= icw4_reg_d;
            ocw2_reg_q  <= ocw2_reg_d;
            rd_sel_q    <= rd_sel_d;
            icw_pulse_q <= icw_pulse_d;
            ocw_pulse_q <= ocw_pulse_d;
            dout_q      <= dout_d;
            dout_en_q   <= dout_en_d;
        end
    end

    assign DOUT      = dout_q;
    assign DOUT_EN   = dout_en_q;
    assign IMR       = imr_q;
    assign ICW_PULSE = icw_pulse_q;
    assign OCW_PULSE = ocw_pulse_q;
    assign LTIM      = ltim_q;
    assign SNGL      = sngl_q;
    assign VEC_BASE  = vec_base_q;
    assign CASC_CFG  = casc_cfg_q;
    assign ICW4_REG  = icw4_reg_q;
    assign OCW2_REG  = ocw2_reg_q;
    assign INIT_DONE = init_done_q;

endmodule
`default_nettype wire

// File: tb/tb_pic_bus_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_pic_bus_if
// Description : Self-checking bench for pic_bus_if (DATA_W=8, CASCADE_EN=1).
//               Directed scenarios followed by randomised bus traffic checked
//               against a queue-based model of the initialisation sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pic_bus_if;

    logic       clk = 1'b0;
    logic       rst_n, cs_n, wr_n, rd_n, a0;
    logic [7:0] din, irr, isr;
    logic [7:0] dout, imr, casc_cfg, ocw2_reg;
    logic       dout_en, ltim, sngl, init_done;
    logic [3:0] icw_pulse;
    logic [2:0] ocw_pulse;
    logic [4:0] vec_base, icw4_reg;

    pic_bus_if #(.DATA_W(8), .CASCADE_EN(1'b1)) dut (
        .CLK(clk), .RST_N(rst_n), .CS_N(cs_n), .WR_N(wr_n), .RD_N(rd_n),
        .A0(a0), .DIN(din), .IRR(irr), .ISR(isr),
        .DOUT(dout), .DOUT_EN(dout_en), .IMR(imr),
        .ICW_PULSE(icw_pulse), .OCW_PULSE(ocw_pulse),
        .LTIM(ltim), .SNGL(sngl), .VEC_BASE(vec_base), .CASC_CFG(casc_cfg),
        .ICW4_REG(icw4_reg), .OCW2_REG(ocw2_reg), .INIT_DONE(init_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Observations captured by the bus tasks
    logic [3:0] obs_icw;
    logic [2:0] obs_ocw;
    int         obs_extra;
    logic [7:0] obs_dout, obs_dout_after;
    logic       obs_en, obs_en_hold, obs_en_after;

    // Reference model: pending = ICW numbers still expected, in order
    int         m_pending[$];
    logic       m_init, m_ltim, m_sngl, m_ic4, m_sel;
    logic [7:0] m_imr, m_casc, m_ocw2;
    logic [4:0] m_vec, m_icw4;

    task automatic model_reset();
        m_pending = {};
        m_init = 0; m_ltim = 0; m_sngl = 1; m_ic4 = 0; m_sel = 0;
        m_imr = 0; m_casc = 0; m_ocw2 = 0; m_vec = 0; m_icw4 = 0;
    endtask

    task automatic model_write(input logic a, input logic [7:0] d,
                               output logic [3:0] ei, output logic [2:0] eo);
        int n;
        ei = 0; eo = 0;
        if (!a && d[4]) begin
            m_ltim = d[3]; m_sngl = d[1]; m_ic4 = d[0];
            m_imr = 0; m_init = 0; m_sel = 0;
            m_pending = {};
            m_pending.push_back(2);
            if (!m_sngl) m_pending.push_back(3);
            if (m_ic4)   m_pending.push_back(4);
            ei = 4'b0001;
        end else if (m_pending.size() != 0) begin
            if (a) begin
                n = m_pending.pop_front();
                if (n == 2) m_vec = d[7:3];
                else if (n == 3) m_casc = d;
                else m_icw4 = d[4:0];
                ei = 4'(1 << (n - 1));
                if (m_pending.size() == 0) begin
                    m_init = 1;
                    if (!m_ic4) m_icw4 = 0;
                end
            end
        end else if (m_init) begin
            if (a) begin
                m_imr = d; eo = 3'b001;
            end else if (d[3] == 1'b0) begin
                m_ocw2 = d; eo = 3'b010;
            end else begin
                eo = 3'b100;
                if (d[1]) m_sel = d[0];
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 0; cs_n = 1; wr_n = 1; rd_n = 1; a0 = 0; din = 0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk) rst_n = 1;
        model_reset();
    endtask

    task automatic bus_write(input logic a, input logic [7:0] d, input int hold);
        @(negedge clk); cs_n = 0; wr_n = 0; a0 = a; din = d;
        @(posedge clk); #1;
        obs_icw = icw_pulse; obs_ocw = ocw_pulse; obs_extra = 0;
        for (int i = 1; i < hold; i++) begin
            @(posedge clk); #1;
            if (icw_pulse != 0 || ocw_pulse != 0) obs_extra++;
        end
        @(negedge clk); wr_n = 1; cs_n = 1;
        @(posedge clk); #1;
        if (icw_pulse != 0 || ocw_pulse != 0) obs_extra++;
    endtask

    task automatic bus_read(input logic a, input int hold);
        @(negedge clk); cs_n = 0; rd_n = 0; a0 = a;
        @(posedge clk); #1;
        obs_dout = dout; obs_en = dout_en; obs_en_hold = 1;
        for (int i = 1; i < hold; i++) begin
            @(posedge clk); #1;
            if (!dout_en) obs_en_hold = 0;
        end
        @(negedge clk); rd_n = 1; cs_n = 1;
        @(posedge clk); #1;
        obs_en_after = dout_en; obs_dout_after = dout;
    endtask

    task automatic test_reset();
        apply_reset();
        n_vec++; if (imr !== 8'h00) begin n_err++; $display("FAIL reset_imr got %h want 00", imr); end
        n_vec++; if (init_done !== 1'b0) begin n_err++; $display("FAIL reset_init_done got %b want 0", init_done); end
        n_vec++; if (sngl !== 1'b1) begin n_err++; $display("FAIL reset_sngl got %b want 1", sngl); end
        n_vec++; if (dout_en !== 1'b0 || dout !== 8'h00) begin n_err++; $display("FAIL reset_dout got %b/%h want 0/00", dout_en, dout); end
        n_vec++; if ({icw_pulse, ocw_pulse, ltim, vec_base, casc_cfg, icw4_reg, ocw2_reg} !== '0) begin
            n_err++; $display("FAIL reset_fields got nonzero pulses/fields");
        end
    endtask

    task automatic test_single();
        bus_write(0, 8'h12, 1);
        n_vec++; if (obs_icw !== 4'b0001) begin n_err++; $display("FAIL single_icw1_pulse got %b want 0001", obs_icw); end
        bus_write(1, 8'h40, 1);
        n_vec++; if (obs_icw !== 4'b0010) begin n_err++; $display("FAIL single_icw2_pulse got %b want 0010", obs_icw); end
        n_vec++; if (vec_base !== 5'h08) begin n_err++; $display("FAIL single_vec_base got %h want 08", vec_base); end
        n_vec++; if (init_done !== 1'b1 || icw4_reg !== 5'd0 || sngl !== 1'b1) begin
            n_err++; $display("FAIL single_done got init=%b icw4=%h sngl=%b want 1/00/1", init_done, icw4_reg, sngl);
        end
    endtask

    task automatic test_cascade();
        logic [7:0] seq [4] = '{8'h11, 8'h20, 8'h04, 8'h01};
        logic       aa  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            bus_write(aa[i], seq[i], 1);
            n_vec++; if (obs_icw !== 4'(1 << i)) begin n_err++; $display("FAIL cascade_pulse%0d got %b want %b", i, obs_icw, 4'(1 << i)); end
            n_vec++; if (init_done !== (i == 3)) begin n_err++; $display("FAIL cascade_init%0d got %b want %b", i, init_done, (i == 3)); end
        end
        n_vec++; if (casc_cfg !== 8'h04 || icw4_reg !== 5'h01 || sngl !== 1'b0) begin
            n_err++; $display("FAIL cascade_fields got casc=%h icw4=%h sngl=%b want 04/01/0", casc_cfg, icw4_reg, sngl);
        end
    endtask

    task automatic test_ocw_read();
        isr = 8'h80; irr = 8'h03;
        bus_write(1, 8'hA5, 1);
        n_vec++; if (imr !== 8'hA5 || obs_ocw !== 3'b001) begin n_err++; $display("FAIL ocw1 got imr=%h pulse=%b want a5/001", imr, obs_ocw); end
        bus_read(1, 3);
        n_vec++; if (obs_dout !== 8'hA5 || obs_en !== 1 || obs_en_hold !== 1) begin
            n_err++; $display("FAIL read_imr got dout=%h en=%b hold=%b want a5/1/1", obs_dout, obs_en, obs_en_hold);
        end
        n_vec++; if (obs_en_after !== 0 || obs_dout_after !== 8'hA5) begin
            n_err++; $display("FAIL read_release got en=%b dout=%h want 0/a5", obs_en_after, obs_dout_after);
        end
        bus_write(0, 8'h0A, 1);
        n_vec++; if (obs_ocw !== 3'b100) begin n_err++; $display("FAIL ocw3_pulse got %b want 100", obs_ocw); end
        bus_read(0, 1);
        n_vec++; if (obs_dout !== 8'h03) begin n_err++; $display("FAIL read_irr got %h want 03", obs_dout); end
        bus_write(0, 8'h0B, 1);
        bus_read(0, 1);
        n_vec++; if (obs_dout !== 8'h80) begin n_err++; $display("FAIL read_isr got %h want 80", obs_dout); end
        bus_write(0, 8'h08, 1);
        bus_read(0, 1);
        n_vec++; if (obs_dout !== 8'h80) begin n_err++; $display("FAIL ocw3_nochange got %h want 80", obs_dout); end
        bus_write(0, 8'h20, 1);
        n_vec++; if (ocw2_reg !== 8'h20 || obs_ocw !== 3'b010) begin n_err++; $display("FAIL ocw2 got reg=%h pulse=%b want 20/010", ocw2_reg, obs_ocw); end
    endtask

    task automatic test_restart();
        bus_write(1, 8'hFF, 1);                 // IMR nonzero before restart
        bus_write(0, 8'h11, 1);
        bus_write(1, 8'h20, 1);
        bus_write(0, 8'h13, 5);
        n_vec++; if (obs_icw !== 4'b0001 || obs_extra !== 0) begin
            n_err++; $display("FAIL long_strobe got pulse=%b extra=%0d want 0001/0", obs_icw, obs_extra);
        end
        n_vec++; if (imr !== 8'h00 || init_done !== 0) begin n_err++; $display("FAIL restart_clear got imr=%h init=%b want 00/0", imr, init_done); end
        bus_write(0, 8'h08, 1);
        n_vec++; if (obs_icw !== 0 || obs_ocw !== 0) begin n_err++; $display("FAIL wait_ignore got %b/%b want 0/0", obs_icw, obs_ocw); end
        bus_write(1, 8'h48, 1);
        n_vec++; if (obs_icw !== 4'b0010 || vec_base !== 5'h09 || init_done !== 0) begin
            n_err++; $display("FAIL restart_icw2 got pulse=%b vec=%h init=%b want 0010/09/0", obs_icw, vec_base, init_done);
        end
        bus_write(1, 8'h03, 1);
        n_vec++; if (obs_icw !== 4'b1000 || icw4_reg !== 5'h03 || init_done !== 1) begin
            n_err++; $display("FAIL restart_icw4 got pulse=%b icw4=%h init=%b want 1000/03/1", obs_icw, icw4_reg, init_done);
        end
    endtask

    task automatic test_simul_and_cs();
        // Write and read fall together: write wins
        @(negedge clk); cs_n = 0; wr_n = 0; rd_n = 0; a0 = 1; din = 8'h3C;
        @(posedge clk); #1;
        n_vec++; if (ocw_pulse !== 3'b001 || dout_en !== 0) begin n_err++; $display("FAIL simul got pulse=%b en=%b want 001/0", ocw_pulse, dout_en); end
        @(posedge clk); #1;
        n_vec++; if (imr !== 8'h3C || dout_en !== 0) begin n_err++; $display("FAIL simul_hold got imr=%h en=%b want 3c/0", imr, dout_en); end
        @(negedge clk); wr_n = 1; rd_n = 1; cs_n = 1;
        // Deselect mid-strobe, reselect with WR_N still low: no new accept
        @(negedge clk); cs_n = 0; wr_n = 0; din = 8'h55;
        @(negedge clk); cs_n = 1;
        @(negedge clk); cs_n = 0; din = 8'h66;
        @(posedge clk); #1;
        n_vec++; if (imr !== 8'h55 || ocw_pulse !== 0) begin n_err++; $display("FAIL cs_reselect got imr=%h pulse=%b want 55/000", imr, ocw_pulse); end
        @(negedge clk); wr_n = 1; cs_n = 1;
    endtask

    task automatic test_reset_mid();
        bus_write(0, 8'h19, 1);
        bus_write(1, 8'h20, 1);                 // now waiting for ICW3
        @(negedge clk); #2 rst_n = 0; #1;
        n_vec++; if (sngl !== 1 || ltim !== 0 || vec_base !== 0 || init_done !== 0 || imr !== 0 || dout_en !== 0) begin
            n_err++; $display("FAIL async_reset got sngl=%b ltim=%b vec=%h init=%b want 1/0/00/0", sngl, ltim, vec_base, init_done);
        end
        @(negedge clk) rst_n = 1;
        model_reset();
        bus_write(1, 8'h04, 1);
        n_vec++; if (obs_icw !== 0 || casc_cfg !== 0 || imr !== 0) begin
            n_err++; $display("FAIL idle_ignore got pulse=%b casc=%h imr=%h want 0/00/00", obs_icw, casc_cfg, imr);
        end
    endtask

    task automatic test_random();
        logic [3:0] ei;
        logic [2:0] eo;
        logic [7:0] d, exp_rd;
        logic       a;
        int         op;
        apply_reset();
        for (int k = 0; k < 300; k++) begin
            op = $urandom_range(0, 9);
            d  = 8'($urandom);
            if (op >= 7) begin
                a = 1'($urandom); irr = 8'($urandom); isr = 8'($urandom);
                exp_rd = a ? m_imr : (m_sel ? isr : irr);
                bus_read(a, $urandom_range(1, 3));
                n_vec++; if (obs_dout !== exp_rd || obs_en !== 1 || obs_en_hold !== 1 || obs_en_after !== 0) begin
                    n_err++; $display("FAIL rand_read%0d got dout=%h en=%b%b%b want %h/110", k, obs_dout, obs_en, obs_en_hold, obs_en_after, exp_rd);
                end
            end else begin
                if (op == 0)      begin a = 0; d[4] = 1; end
                else if (op <= 4) begin a = 1; end
                else if (op == 5) begin a = 0; d[4:3] = 2'b00; end
                else              begin a = 0; d[4:3] = 2'b01; end
                model_write(a, d, ei, eo);
                bus_write(a, d, $urandom_range(1, 3));
                n_vec++; if (obs_icw !== ei || obs_ocw !== eo || obs_extra !== 0) begin
                    n_err++; $display("FAIL rand_pulse%0d got %b/%b x%0d want %b/%b", k, obs_icw, obs_ocw, obs_extra, ei, eo);
                end
                n_vec++; if ({imr, init_done, ltim, sngl, vec_base, casc_cfg, icw4_reg, ocw2_reg} !==
                             {m_imr, m_init, m_ltim, m_sngl, m_vec, m_casc, m_icw4, m_ocw2}) begin
                    n_err++; $display("FAIL rand_state%0d got %h want %h", k,
                        {imr, init_done, ltim, sngl, vec_base, casc_cfg, icw4_reg, ocw2_reg},
                        {m_imr, m_init, m_ltim, m_sngl, m_vec, m_casc, m_icw4, m_ocw2});
                end
            end
        end
    endtask

    initial begin
        rst_n = 0; cs_n = 1; wr_n = 1; rd_n = 1; a0 = 0; din = 0; irr = 0; isr = 0;
        test_reset();
        test_single();
        test_cascade();
        test_ocw_read();
        test_restart();
        test_simul_and_cs();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout after %0d vectors", n_vec);
        $fatal(1);
    end

endmodule
`default_nettype wire
